// File: rtl/frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_scheduler_if
// Description : Register-write and LED-driver frame bus between the SPI
//               register layer / LED driver and the frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_scheduler_if #(
    parameter int FRAME_BYTES = 8
);
    // Register write channel
    logic                     wr_valid;
    logic [3:0]               wr_addr;
    logic [7:0]               wr_data;
    logic                     wr_ready;

    // LED driver side
    logic                     frame_done;
    logic [FRAME_BYTES*8-1:0] frame_buffer;
    logic [5:0]               frame_done_index;

    // Status
    logic                     commit_pending;
    logic                     commit_pulse;
    logic [7:0]               frame_count;

    // Host / driver side (drives writes and frame_done)
    modport master (
        output wr_valid, wr_addr, wr_data, frame_done,
        input  wr_ready, frame_buffer, frame_done_index,
               commit_pending, commit_pulse, frame_count
    );

    // Scheduler side
    modport slave (
        input  wr_valid, wr_addr, wr_data, frame_done,
        output wr_ready, frame_buffer, frame_done_index,
               commit_pending, commit_pulse, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_scheduler
// Description : Double-buffered frame controller. Byte writes land in a
//               shadow frame that is copied to the active frame only on the
//               driver's frame_done pulse; the active frame can be animated
//               (blink / inverse-blink / byte rotate) between commits.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_scheduler #(
    parameter int FRAME_BYTES = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    frame_scheduler_if.slave  bus
);

    localparam int FRAME_W = FRAME_BYTES * 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam logic [1:0] MODE_STATIC  = 2'b00;
    localparam logic [1:0] MODE_BLINK   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;
    localparam logic [1:0] MODE_INVERSE = 2'b11;

    localparam logic [3:0] ADDR_CTRL  = 4'd8;
    localparam logic [3:0] ADDR_HOLD  = 4'd9;
    localparam logic [3:0] ADDR_INDEX = 4'd10;

    // FSM state
    logic [0:0]         state_q, state_d;

    // Datapath state
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [5:0]         shadow_index_q, shadow_index_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic [5:0]         active_index_q, active_index_d;
    logic               auto_q, auto_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         hold_q, hold_d;
    logic [7:0]         step_cnt_q, step_cnt_d;
    logic               phase_q, phase_d;
    logic [2:0]         rot_q, rot_d;
    logic [7:0]         frame_count_q, frame_count_d;
    logic               commit_pulse_q, commit_pulse_d;

    // Decoded controls
    logic               wr_ready;
    logic               commit_pending;
    logic               wr_fire;
    logic               arm;
    logic               commit;
    logic [7:0]         step_inc;
    logic [FRAME_W-1:0] rotated;
    logic [FRAME_W-1:0] frame_out;

    assign wr_fire  = bus.wr_valid & wr_ready;
    // Arming uses the AUTO value already stored, so a CTRL write that sets
    // AUTO does not itself count as a byte-7 write.
    assign arm      = wr_fire &
                      (((bus.wr_addr == ADDR_CTRL) & bus.wr_data[0]) |
                       ((bus.wr_addr == 4'd7) & auto_q));
    assign commit   = (state_q == ST_ARMED) & bus.frame_done;
    assign step_inc = step_cnt_q + 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: arm on a commit request, return on frame_done
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arm)            state_d = ST_ARMED;
            ST_ARMED: if (bus.frame_done) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: writes are stalled while a commit is armed
    always_comb begin
        wr_ready       = 1'b0;
        commit_pending = 1'b0;
        case (state_q)
            ST_IDLE:  wr_ready       = 1'b1;
            ST_ARMED: commit_pending = 1'b1;
            default:  wr_ready       = 1'b0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q       <= '0;
            shadow_index_q <= '0;
            active_q       <= '0;
            active_index_q <= '0;
            auto_q         <= 1'b0;
            mode_q         <= MODE_STATIC;
            hold_q         <= 8'd1;
            step_cnt_q     <= '0;
            phase_q        <= 1'b0;
            rot_q          <= '0;
            frame_count_q  <= '0;
            commit_pulse_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_index_q <= shadow_index_d;
            active_q       <= active_d;
            active_index_q <= active_index_d;
            auto_q         <= auto_d;
            mode_q         <= mode_d;
            hold_q         <= hold_d;
            step_cnt_q     <= step_cnt_d;
            phase_q        <= phase_d;
            rot_q          <= rot_d;
            frame_count_q  <= frame_count_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

    // Register writes, commit copy and animation stepping
    always_comb begin
        shadow_d       = shadow_q;
        shadow_index_d = shadow_index_q;
        active_d       = active_q;
        active_index_d = active_index_q;
        auto_d         = auto_q;
        mode_d         = mode_q;
        hold_d         = hold_q;
        step_cnt_d     = step_cnt_q;
        phase_d        = phase_q;
        rot_d          = rot_q;
        frame_count_d  = frame_count_q;
        commit_pulse_d = commit;

        if (wr_fire) begin
            if (!bus.wr_addr[3]) begin
                shadow_d[{bus.wr_addr[2:0], 3'b000} +: 8] = bus.wr_data;
            end else begin
                case (bus.wr_addr)
                    ADDR_CTRL: begin
                        auto_d = bus.wr_data[1];
                        mode_d = bus.wr_data[3:2];
                    end
                    ADDR_HOLD:  hold_d         = bus.wr_data;
                    ADDR_INDEX: shadow_index_d = bus.wr_data[5:0];
                    default:    ;
                endcase
            end
        end

        if (commit) begin
            active_d       = shadow_q;
            active_index_d = shadow_index_q;
            step_cnt_d     = '0;
            phase_d        = 1'b0;
            rot_d          = '0;
            frame_count_d  = frame_count_q + 8'd1;
        end else if (bus.frame_done && (hold_q != 8'd0)) begin
            // Counter is not cleared by HOLD writes, so a counter already
            // past HOLD only steps again after it wraps through 255.
            if (step_inc == hold_q) begin
                step_cnt_d = '0;
                phase_d    = ~phase_q;
                rot_d      = rot_q + 3'd1;
            end else begin
                step_cnt_d = step_inc;
            end
        end
    end

    // Byte rotation: output byte i is active byte (i + rot) mod 8
    for (genvar i = 0; i < FRAME_BYTES; i++) begin : g_rot
        assign rotated[i*8 +: 8] = active_q[{3'(i) + rot_q, 3'b000} +: 8];
    end

    // Displayed frame is a function of registered state only
    always_comb begin
        frame_out = active_q;
        case (mode_q)
            MODE_STATIC:  frame_out = active_q;
            MODE_BLINK:   frame_out = phase_q ? '0 : active_q;
            MODE_ROTATE:  frame_out = rotated;
            MODE_INVERSE: frame_out = phase_q ? ~active_q : active_q;
            default:      frame_out = active_q;
        endcase
    end

    assign bus.wr_ready         = wr_ready;
    assign bus.commit_pending   = commit_pending;
    assign bus.commit_pulse     = commit_pulse_q;
    assign bus.frame_count      = frame_count_q;
    assign bus.frame_buffer     = frame_out;
    assign bus.frame_done_index = active_index_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_scheduler
// Description : Directed self-checking bench for frame_scheduler with an
//               expected-value scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    logic clk;
    logic rst_n;

    frame_scheduler_if #(.FRAME_BYTES(8)) bus ();

    frame_scheduler #(.FRAME_BYTES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [63:0] FRAME_A = 64'h0807060504030201;

    // Queue an expected value when the stimulus is applied
    task automatic sb_push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows
    task automatic sb_check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    // Starts and ends at a falling edge; waits (bounded) for wr_ready
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int n;
        n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        while (bus.wr_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            assert (n < 200) else begin
                failures++;
                $error("FAIL write_timeout observed=%0d expected=<200", n);
            end
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_fd();
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.frame_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        expect_now("rst_fb",      bus.frame_buffer,            64'h0);
        expect_now("rst_index",   64'(bus.frame_done_index),   64'h0);
        expect_now("rst_count",   64'(bus.frame_count),        64'h0);
        expect_now("rst_ready",   64'(bus.wr_ready),           64'h1);
        expect_now("rst_pending", 64'(bus.commit_pending),     64'h0);
        expect_now("rst_pulse",   64'(bus.commit_pulse),       64'h0);

        // Shadow writes without commit never reach the display
        for (int i = 0; i < 8; i++) do_write(4'(i), 8'(i + 1));
        repeat (3) pulse_fd();
        expect_now("nocommit_fb",    bus.frame_buffer,     64'h0);
        expect_now("nocommit_count", 64'(bus.frame_count), 64'h0);

        // Explicit commit
        do_write(4'd10, 8'h15);
        do_write(4'd8, 8'h01);
        expect_now("arm_pending", 64'(bus.commit_pending), 64'h1);
        expect_now("arm_ready",   64'(bus.wr_ready),       64'h0);
        repeat (5) @(negedge clk);
        expect_now("armed_fb_old", bus.frame_buffer, 64'h0);
        sb_push("commit_fb",    FRAME_A);
        sb_push("commit_index", 64'h15);
        sb_push("commit_pulse", 64'h1);
        sb_push("commit_count", 64'h1);
        sb_push("commit_ready", 64'h1);
        pulse_fd();
        sb_check(bus.frame_buffer);
        sb_check(64'(bus.frame_done_index));
        sb_check(64'(bus.commit_pulse));
        sb_check(64'(bus.frame_count));
        sb_check(64'(bus.wr_ready));
        @(negedge clk);
        expect_now("commit_pulse_end", 64'(bus.commit_pulse), 64'h0);

        // Write stalled in ARMED lands in shadow only after the commit
        do_write(4'd8, 8'h01);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_now("stall_ready", 64'(bus.wr_ready), 64'h0);
        end
        pulse_fd();
        expect_now("stall_commit_ready", 64'(bus.wr_ready), 64'h1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        expect_now("stall_byte0",   64'(bus.frame_buffer[7:0]), 64'h01);
        expect_now("stall_count",   64'(bus.frame_count),       64'h2);
        expect_now("stall_pending", 64'(bus.commit_pending),    64'h0);

        // Rotate with HOLD=2
        do_write(4'd8, 8'h08);
        do_write(4'd9, 8'd2);
        expect_now("rot0_fb", bus.frame_buffer, FRAME_A);
        repeat (2) pulse_fd();
        expect_now("rot1_fb", bus.frame_buffer, 64'h0108070605040302);
        repeat (2) pulse_fd();
        expect_now("rot2_fb",    bus.frame_buffer,              64'h0201080706050403);
        expect_now("rot2_byte0", 64'(bus.frame_buffer[7:0]),    64'h03);
        expect_now("rot2_byte7", 64'(bus.frame_buffer[63:56]),  64'h02);

        // Blink with HOLD=1, then freeze with HOLD=0
        do_write(4'd8, 8'h04);
        do_write(4'd9, 8'd1);
        expect_now("blink_start", bus.frame_buffer, FRAME_A);
        pulse_fd();
        expect_now("blink_off1", bus.frame_buffer, 64'h0);
        pulse_fd();
        expect_now("blink_on",   bus.frame_buffer, FRAME_A);
        pulse_fd();
        expect_now("blink_off2", bus.frame_buffer, 64'h0);
        do_write(4'd9, 8'd0);
        repeat (2) pulse_fd();
        expect_now("blink_frozen", bus.frame_buffer, 64'h0);

        // AUTO commit: byte-7 write coincident with frame_done waits a frame
        do_write(4'd8, 8'h02);
        expect_now("auto_static_fb", bus.frame_buffer, FRAME_A);
        bus.wr_valid   = 1'b1;
        bus.wr_addr    = 4'd7;
        bus.wr_data    = 8'h77;
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.wr_valid   = 1'b0;
        bus.frame_done = 1'b0;
        expect_now("auto_pending",  64'(bus.commit_pending), 64'h1);
        expect_now("auto_nocommit", 64'(bus.frame_count),    64'h2);
        expect_now("auto_fb_old",   bus.frame_buffer,        FRAME_A);
        sb_push("auto_fb",    64'h77070605040302AA);
        sb_push("auto_count", 64'h3);
        sb_push("auto_pulse", 64'h1);
        pulse_fd();
        sb_check(bus.frame_buffer);
        sb_check(64'(bus.frame_count));
        sb_check(64'(bus.commit_pulse));

        // Reset while ARMED discards the commit
        do_write(4'd8, 8'h03);
        expect_now("rearm_pending", 64'(bus.commit_pending), 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_now("mrst_fb",      bus.frame_buffer,          64'h0);
        expect_now("mrst_count",   64'(bus.frame_count),      64'h0);
        expect_now("mrst_pending", 64'(bus.commit_pending),   64'h0);
        expect_now("mrst_ready",   64'(bus.wr_ready),         64'h1);
        expect_now("mrst_index",   64'(bus.frame_done_index), 64'h0);
        pulse_fd();
        expect_now("mrst_fd_fb",    bus.frame_buffer,        64'h0);
        expect_now("mrst_fd_count", 64'(bus.frame_count),    64'h0);
        expect_now("mrst_fd_pulse", 64'(bus.commit_pulse),   64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
